uart_rx: RTL and testbench

- UART serial receiver; consumes the 16x-oversampling tick from the baud-rate generator and the asynchronous rx pin.
- Recovers frames of 1 start bit, DBIT data bits (LSB first) and a stop bit, with no parity.
- Presents each received word with a one-cycle done strobe and a framing-error flag to the downstream FIFO or consumer.

---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Handshake bundle between a UART receiver and whatever drives its line and
// tick (master) and consumes its received words.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
    logic            busy;

    modport master (
        output rx,
        output s_tick,
        input  dout,
        input  rx_done_tick,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        input  s_tick,
        output dout,
        output rx_done_tick,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: recovers start / DBIT data (LSB first) / stop frames from a
// 16x oversampling tick, presenting each word with a done strobe and framing flag.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int S_MAX = (SB_TICK - 1 > 15) ? SB_TICK - 1 : 15;
    localparam int S_W   = $clog2(S_MAX + 1);
    localparam int N_W   = $clog2(DBIT);

    localparam logic [S_W-1:0] S_ONE      = S_W'(1);
    localparam logic [S_W-1:0] S_MID      = S_W'(7);
    localparam logic [S_W-1:0] S_BIT_END  = S_W'(15);
    localparam logic [S_W-1:0] S_STOP_END = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_ONE      = N_W'(1);
    localparam logic [N_W-1:0] N_LAST     = N_W'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            frame_err_q, frame_err_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            rx_s;

    // Synchronizer flops idle high so reset never looks like a start edge.
    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            dout_q      <= '0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        sync_d      = {sync_q[0], bus.rx};
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        done_d      = 1'b0;

        unique case (state_q)
            // Start detection runs every clock; a tick in this clock is not counted.
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s_q == S_BIT_END) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + N_ONE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (s_q == S_STOP_END) begin
                        state_d     = IDLE;
                        dout_d      = b_q;
                        frame_err_d = ~rx_s;
                        done_d      = 1'b1;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.dout         = dout_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.rx_done_tick = done_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: an 8N1 receiver and a 7-bit / 2-stop receiver
// driven from one 16x tick, checked against a frame-level expectation model.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int LAT8 = 8 + 16 * 8 + 16;
    localparam int LAT7 = 8 + 16 * 7 + 32;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         t;
        logic       busy;
    } done_t;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    logic  tick = 1'b0;
    int    tick_num = 0;
    int    phase = 0;
    int    busy_cnt8 = 0;
    int    n_compared = 0;
    int    n_mismatched = 0;
    done_t q8[$];
    done_t q7[$];
    done_t e8;
    done_t e7;

    uart_rx_if #(.DBIT(8)) bus8();
    uart_rx_if #(.DBIT(7)) bus7();

    assign bus8.s_tick = tick;
    assign bus7.s_tick = tick;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (.clk(clk), .reset(reset), .bus(bus7));

    always #5 clk = ~clk;

    // One tick every 4 clocks; tick_num counts ticks already seen by the DUTs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick) tick_num++;
            tick  = (phase == 3);
            phase = (phase + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (bus8.busy === 1'b1) busy_cnt8++;
        if (bus8.rx_done_tick === 1'b1) begin
            e8.data = bus8.dout;
            e8.ferr = bus8.frame_err;
            e8.t    = tick_num;
            e8.busy = bus8.busy;
            q8.push_back(e8);
        end
        if (bus7.rx_done_tick === 1'b1) begin
            e7.data = {1'b0, bus7.dout};
            e7.ferr = bus7.frame_err;
            e7.t    = tick_num;
            e7.busy = bus7.busy;
            q7.push_back(e7);
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic wait_tick();
        do @(posedge clk); while (tick !== 1'b1);
    endtask

    task automatic set_rx(input bit use7, input logic v);
        #2;
        if (use7) bus7.rx = v;
        else      bus8.rx = v;
    endtask

    task automatic idle_ticks(input bit use7, input int n);
        set_rx(use7, 1'b1);
        repeat (n) wait_tick();
    endtask

    // A bad stop is held low just past the sample point, so the START that the
    // receiver re-arms on the low line is rejected at its midpoint.
    task automatic applyStimulus(input bit use7, input logic [7:0] data, input bit stop_ok,
                                 output int start_tick);
        int dbit;
        int sbt;
        dbit = use7 ? 7 : 8;
        sbt  = use7 ? 32 : 16;
        set_rx(use7, 1'b0);
        start_tick = tick_num;
        repeat (16) wait_tick();
        for (int i = 0; i < dbit; i++) begin
            set_rx(use7, data[i]);
            repeat (16) wait_tick();
        end
        if (stop_ok) begin
            set_rx(use7, 1'b1);
            repeat (sbt) wait_tick();
        end else begin
            set_rx(use7, 1'b0);
            repeat (sbt - 6) wait_tick();
            set_rx(use7, 1'b1);
            repeat (6) wait_tick();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_compared++;
        if (bus8.dout !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_dout8: got %h, expected 00", bus8.dout); end
        n_compared++;
        if (bus7.dout !== 7'h00) begin n_mismatched++; $display("[TB] FAIL reset_dout7: got %h, expected 00", bus7.dout); end
        n_compared++;
        if (bus8.frame_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ferr: got %b, expected 0", bus8.frame_err); end
        n_compared++;
        if (bus8.rx_done_tick !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b, expected 0", bus8.rx_done_tick); end
        n_compared++;
        if (bus8.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus8.busy); end
        @(negedge clk);
        reset = 1'b0;
        wait_tick();
        repeat (20) wait_tick();
        #3;
        n_compared++;
        if (bus8.busy !== 1'b0 || q8.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL idle_quiet: busy %b, strobes %0d, expected busy 0 and 0 strobes", bus8.busy, q8.size());
        end
    endtask

    task automatic test_single_frame();
        int st;
        wait_tick();
        q8.delete();
        busy_cnt8 = 0;
        applyStimulus(1'b0, 8'hA5, 1'b1, st);
        idle_ticks(1'b0, 8);
        #3;
        n_compared++;
        if (q8.size() != 1) begin n_mismatched++; $display("[TB] FAIL a5_count: got %0d strobes, expected 1", q8.size()); end
        if (q8.size() >= 1) begin
            n_compared++;
            if (q8[0].data !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL a5_data: got %h, expected a5", q8[0].data); end
            n_compared++;
            if (q8[0].ferr !== 1'b0) begin n_mismatched++; $display("[TB] FAIL a5_ferr: got %b, expected 0", q8[0].ferr); end
            n_compared++;
            if (q8[0].t - st != LAT8) begin n_mismatched++; $display("[TB] FAIL a5_latency: got %0d ticks, expected %0d", q8[0].t - st, LAT8); end
            n_compared++;
            if (q8[0].busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL a5_busy_at_done: got %b, expected 0", q8[0].busy); end
        end
        // Busy spans from 3 clocks after the start edge to the final stop tick.
        n_compared++;
        if (busy_cnt8 != LAT8 * 4 - 3) begin n_mismatched++; $display("[TB] FAIL a5_busy_cycles: got %0d, expected %0d", busy_cnt8, LAT8 * 4 - 3); end
        n_compared++;
        if (bus8.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL a5_busy_after: got %b, expected 0", bus8.busy); end
    endtask

    task automatic test_glitch();
        wait_tick();
        q8.delete();
        busy_cnt8 = 0;
        set_rx(1'b0, 1'b0);
        repeat (3) wait_tick();
        #3;
        n_compared++;
        if (bus8.busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL glitch_busy_during: got %b, expected 1", bus8.busy); end
        set_rx(1'b0, 1'b1);
        repeat (40) wait_tick();
        #3;
        n_compared++;
        if (q8.size() != 0) begin n_mismatched++; $display("[TB] FAIL glitch_strobe: got %0d strobes, expected 0", q8.size()); end
        n_compared++;
        if (bus8.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL glitch_busy_after: got %b, expected 0", bus8.busy); end
        n_compared++;
        if (bus8.dout !== 8'hA5 || bus8.frame_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL glitch_hold: got dout %h ferr %b, expected a5 0", bus8.dout, bus8.frame_err);
        end
        n_compared++;
        if (busy_cnt8 != 8 * 4 - 3) begin n_mismatched++; $display("[TB] FAIL glitch_busy_cycles: got %0d, expected %0d", busy_cnt8, 8 * 4 - 3); end
    endtask

    task automatic test_framing_error();
        int st1;
        int st2;
        wait_tick();
        q8.delete();
        applyStimulus(1'b0, 8'h3C, 1'b0, st1);
        idle_ticks(1'b0, 16);
        applyStimulus(1'b0, 8'h81, 1'b1, st2);
        idle_ticks(1'b0, 8);
        #3;
        n_compared++;
        if (q8.size() != 2) begin n_mismatched++; $display("[TB] FAIL ferr_count: got %0d strobes, expected 2", q8.size()); end
        if (q8.size() >= 2) begin
            n_compared++;
            if (q8[0].data !== 8'h3C || q8[0].ferr !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL ferr_bad_frame: got %h/%b, expected 3c/1", q8[0].data, q8[0].ferr);
            end
            n_compared++;
            if (q8[1].data !== 8'h81 || q8[1].ferr !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL ferr_good_frame: got %h/%b, expected 81/0", q8[1].data, q8[1].ferr);
            end
            n_compared++;
            if (q8[0].t - st1 != LAT8 || q8[1].t - st2 != LAT8) begin
                n_mismatched++;
                $display("[TB] FAIL ferr_latency: got %0d/%0d, expected %0d", q8[0].t - st1, q8[1].t - st2, LAT8);
            end
        end
    endtask

    task automatic test_back_to_back();
        int st1;
        int st2;
        wait_tick();
        q8.delete();
        applyStimulus(1'b0, 8'h00, 1'b1, st1);
        applyStimulus(1'b0, 8'hFF, 1'b1, st2);
        idle_ticks(1'b0, 8);
        #3;
        n_compared++;
        if (q8.size() != 2) begin n_mismatched++; $display("[TB] FAIL b2b_count: got %0d strobes, expected 2", q8.size()); end
        if (q8.size() >= 2) begin
            n_compared++;
            if (q8[0].data !== 8'h00 || q8[1].data !== 8'hFF) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_data: got %h then %h, expected 00 then ff", q8[0].data, q8[1].data);
            end
            n_compared++;
            if (q8[1].t - q8[0].t != 160) begin n_mismatched++; $display("[TB] FAIL b2b_spacing: got %0d ticks, expected 160", q8[1].t - q8[0].t); end
            n_compared++;
            if (q8[0].ferr !== 1'b0 || q8[1].ferr !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_ferr: got %b/%b, expected 0/0", q8[0].ferr, q8[1].ferr);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int st;
        logic [7:0] pattern;
        wait_tick();
        q8.delete();
        pattern = 8'h55;
        set_rx(1'b0, 1'b0);
        repeat (16) wait_tick();
        for (int i = 0; i < 3; i++) begin
            set_rx(1'b0, pattern[i]);
            repeat (16) wait_tick();
        end
        #3;
        reset = 1'b1;
        bus8.rx = 1'b1;
        #1;
        n_compared++;
        if (bus8.dout !== 8'h00 || bus8.frame_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_outputs: got dout %h ferr %b, expected 00 0", bus8.dout, bus8.frame_err);
        end
        n_compared++;
        if (bus8.busy !== 1'b0 || bus8.rx_done_tick !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_flags: got busy %b done %b, expected 0 0", bus8.busy, bus8.rx_done_tick);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_tick();
        repeat (20) wait_tick();
        #3;
        n_compared++;
        if (q8.size() != 0) begin n_mismatched++; $display("[TB] FAIL midrst_strobe: got %0d strobes, expected 0", q8.size()); end
        applyStimulus(1'b0, 8'h5A, 1'b1, st);
        idle_ticks(1'b0, 8);
        #3;
        n_compared++;
        if (q8.size() != 1) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_next_count: got %0d strobes, expected 1", q8.size());
        end else if (q8[0].data !== 8'h5A || q8[0].ferr !== 1'b0 || q8[0].t - st != LAT8) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_next_frame: got %h/%b/%0d, expected 5a/0/%0d", q8[0].data, q8[0].ferr, q8[0].t - st, LAT8);
        end
    endtask

    task automatic test_break();
        int st;
        wait_tick();
        q8.delete();
        set_rx(1'b0, 1'b0);
        st = tick_num;
        repeat (160) wait_tick();
        set_rx(1'b0, 1'b1);
        repeat (200) wait_tick();
        #3;
        n_compared++;
        if (q8.size() != 2) begin n_mismatched++; $display("[TB] FAIL break_count: got %0d strobes, expected 2", q8.size()); end
        if (q8.size() >= 2) begin
            n_compared++;
            if (q8[0].data !== 8'h00 || q8[0].ferr !== 1'b1 || q8[0].t - st != LAT8) begin
                n_mismatched++;
                $display("[TB] FAIL break_frame: got %h/%b/%0d, expected 00/1/%0d", q8[0].data, q8[0].ferr, q8[0].t - st, LAT8);
            end
            n_compared++;
            if (q8[1].data !== 8'hFF || q8[1].ferr !== 1'b0 || q8[1].t - st != 2 * LAT8) begin
                n_mismatched++;
                $display("[TB] FAIL break_rearm: got %h/%b/%0d, expected ff/0/%0d", q8[1].data, q8[1].ferr, q8[1].t - st, 2 * LAT8);
            end
        end
    endtask

    task automatic test_random();
        done_t exp_q[$];
        done_t e;
        int    st;
        logic [7:0] d;
        bit    ok;
        wait_tick();
        q8.delete();
        for (int f = 0; f < 6; f++) begin
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            applyStimulus(1'b0, d, ok, st);
            e.data = d;
            e.ferr = !ok;
            e.t    = st + LAT8;
            e.busy = 1'b0;
            exp_q.push_back(e);
            idle_ticks(1'b0, int'($urandom_range(0, 40)));
        end
        idle_ticks(1'b0, 8);
        #3;
        n_compared++;
        if (q8.size() != exp_q.size()) begin
            n_mismatched++;
            $display("[TB] FAIL rand_count: got %0d strobes, expected %0d", q8.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q8.size(); i++) begin
            n_compared++;
            if (q8[i].data !== exp_q[i].data || q8[i].ferr !== exp_q[i].ferr || q8[i].t != exp_q[i].t) begin
                n_mismatched++;
                $display("[TB] FAIL rand_frame%0d: got %h/%b/t%0d, expected %h/%b/t%0d", i,
                         q8[i].data, q8[i].ferr, q8[i].t, exp_q[i].data, exp_q[i].ferr, exp_q[i].t);
            end
        end
    endtask

    task automatic test_dbit7();
        int st1;
        int st2;
        logic [7:0] d;
        bit ok;
        wait_tick();
        q7.delete();
        applyStimulus(1'b1, 8'h7F, 1'b1, st1);
        idle_ticks(1'b1, 8);
        d  = 8'($urandom_range(0, 127));
        ok = ($urandom_range(0, 1) != 0);
        applyStimulus(1'b1, d, ok, st2);
        idle_ticks(1'b1, 8);
        #3;
        n_compared++;
        if (q7.size() != 2) begin n_mismatched++; $display("[TB] FAIL d7_count: got %0d strobes, expected 2", q7.size()); end
        if (q7.size() >= 2) begin
            n_compared++;
            if (q7[0].data !== 8'h7F || q7[0].ferr !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL d7_7f: got %h/%b, expected 7f/0", q7[0].data, q7[0].ferr);
            end
            n_compared++;
            if (q7[0].t - (st1 + 8 + 16 * 7) != 32) begin
                n_mismatched++;
                $display("[TB] FAIL d7_stop_ticks: got %0d, expected 32", q7[0].t - (st1 + 8 + 16 * 7));
            end
            n_compared++;
            if (q7[1].data !== d || q7[1].ferr !== !ok || q7[1].t - st2 != LAT7) begin
                n_mismatched++;
                $display("[TB] FAIL d7_rand: got %h/%b/%0d, expected %h/%b/%0d", q7[1].data, q7[1].ferr,
                         q7[1].t - st2, d, !ok, LAT7);
            end
        end
    endtask

    initial begin
        bus8.rx = 1'b1;
        bus7.rx = 1'b1;
        reset   = 1'b1;
        $display("[TB] starting uart_rx checks");
        test_reset();
        test_single_frame();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_break();
        test_random();
        test_dbit7();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
